// File: rtl/cfg_seq_pkg.sv
// rtl/cfg_seq_pkg.sv - shared state encoding and LUT entry field positions for the config sequencer
package cfg_seq_pkg;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_PWRUP  = 4'd1,
      S_FETCH  = 4'd2,
      S_ISSUE  = 4'd3,
      S_WAIT   = 4'd4,
      S_SETTLE = 4'd5,
      S_NEXT   = 4'd6,
      S_DONE   = 4'd7,
      S_ERROR  = 4'd8
   } state_t;

   // LUT entry layout: {reg_addr[15:0], reg_data[7:0]}
   localparam int ADDR_MSB = 23;
   localparam int ADDR_LSB = 8;
   localparam int DATA_MSB = 7;

endpackage

// File: rtl/i2c_cfg_sequencer.sv
// rtl/i2c_cfg_sequencer.sv - walks a sensor config LUT and issues 16-bit-address register writes
// Power-up wait, post-soft-reset settle delay and per-entry NACK retry live in one FSM.
module i2c_cfg_sequencer
   import cfg_seq_pkg::*;
#(
   parameter int          CLK_FREQ     = 25_000_000,
   parameter logic [23:0] PWRUP_CYCLES = 24'(CLK_FREQ / 50),
   parameter logic [8:0]  RST_IDX      = 9'd1,
   parameter logic [23:0] RST_CYCLES   = 24'(CLK_FREQ / 200),
   parameter logic [2:0]  MAX_RETRY    = 3'd3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [8:0]  lut_index,
   input  logic [23:0] lut_data,
   input  logic [8:0]  lut_size,
   output logic        wr_valid,
   input  logic        wr_ready,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data,
   input  logic        wr_done,
   input  logic        wr_nack,
   output logic        busy,
   output logic        cfg_done,
   output logic        cfg_err,
   output logic [8:0]  err_index
);

   state_t      state;
   state_t      state_nx;
   logic [8:0]  size;
   logic [2:0]  retry;
   logic [23:0] cnt;
   logic [23:0] cnt_term;
   logic        cnt_hit;
   logic        last_entry;

   // One delay counter serves both PWRUP and SETTLE; only the terminal count differs.
   assign cnt_term   = (state == S_SETTLE) ? RST_CYCLES : PWRUP_CYCLES;
   assign cnt_hit    = (cnt + 24'd1) >= cnt_term;
   assign last_entry = (lut_index == size - 9'd1);

   assign wr_valid = (state == S_ISSUE);
   assign cfg_done = (state == S_DONE);
   assign cfg_err  = (state == S_ERROR);
   assign busy     = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) state_nx = (lut_size == 9'd0) ? S_DONE : S_PWRUP;
         end
         S_PWRUP:  if (cnt_hit) state_nx = S_FETCH;
         S_FETCH:  state_nx = S_ISSUE;
         S_ISSUE:  if (wr_ready) state_nx = S_WAIT;
         S_WAIT: begin
            if (wr_done) begin
               if (!wr_nack)               state_nx = (lut_index == RST_IDX) ? S_SETTLE : S_NEXT;
               else if (retry < MAX_RETRY) state_nx = S_ISSUE;
               else                        state_nx = S_ERROR;
            end
         end
         S_SETTLE: if (cnt_hit) state_nx = S_NEXT;
         S_NEXT:   state_nx = last_entry ? S_DONE : S_FETCH;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         size      <= '0;
         lut_index <= '0;
         retry     <= '0;
         cnt       <= '0;
         wr_addr   <= '0;
         wr_data   <= '0;
         err_index <= '0;
      end else begin
         state <= state_nx;
         cnt   <= (state_nx != state) ? 24'd0 : cnt + 24'd1;
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  size      <= lut_size;
                  lut_index <= '0;
                  retry     <= '0;
                  err_index <= '0;
               end
            end
            S_FETCH: begin
               wr_addr <= lut_data[ADDR_MSB:ADDR_LSB];
               wr_data <= lut_data[DATA_MSB:0];
            end
            S_WAIT: begin
               if (wr_done && wr_nack) begin
                  if (retry < MAX_RETRY) retry     <= retry + 3'd1;
                  else                   err_index <= lut_index;
               end
            end
            S_NEXT: begin
               retry <= '0;
               if (!last_entry) lut_index <= lut_index + 9'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// tb/tb_i2c_cfg_sequencer.sv - directed self-checking bench for i2c_cfg_sequencer
module tb_i2c_cfg_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [8:0]  lut_index;
   logic [23:0] lut_data;
   logic [8:0]  lut_size;
   logic        wr_valid;
   logic        wr_ready = 1'b0;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   logic        wr_done = 1'b0;
   logic        wr_nack = 1'b0;
   logic        busy;
   logic        cfg_done;
   logic        cfg_err;
   logic [8:0]  err_index;

   always #5 clk = ~clk;

   logic [23:0] lut [0:3];
   assign lut_data = (lut_index < 9'd4) ? lut[lut_index[1:0]] : 24'h0;

   i2c_cfg_sequencer #(
      .PWRUP_CYCLES(24'd10),
      .RST_CYCLES  (24'd20),
      .MAX_RETRY   (3'd2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .lut_index(lut_index),
      .lut_data (lut_data),
      .lut_size (lut_size),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_done  (wr_done),
      .wr_nack  (wr_nack),
      .busy     (busy),
      .cfg_done (cfg_done),
      .cfg_err  (cfg_err),
      .err_index(err_index)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // slave model state and transaction log
   int          phase = 0;
   int          dly = 0;
   bit          seen = 0;
   int          cur_vcyc = 0;
   bit          stall_armed = 0;
   int          stall_idx = -1;
   int          stall_n = 0;
   int          stall_left = 0;
   int          stall_cnt = 0;
   int          nack_idx = -1;
   int          nack_left = 0;
   int          n_done = 0;
   int          q_idx[$];
   int          q_vcyc[$];
   int          q_dcyc[$];
   logic [15:0] q_addr[$];
   logic [7:0]  q_data[$];

   initial begin
      forever begin
         @(negedge clk);
         wr_done = 1'b0;
         wr_nack = 1'b0;
         if (rst) begin
            phase = 0; seen = 0; wr_ready = 1'b0;
         end else if (phase == 0) begin
            if (wr_valid && !seen) begin
               seen = 1;
               cur_vcyc = cyc;
               if (stall_armed && lut_index == 9'(stall_idx)) begin
                  stall_left = stall_n;
                  stall_armed = 0;
               end
            end
            if (stall_left > 0) begin
               check_eq("stall_valid", 32'(wr_valid), 32'd1);
               check_eq("stall_addr", 32'(wr_addr), 32'h3008);
               check_eq("stall_data", 32'(wr_data), 32'h82);
               stall_left--;
               stall_cnt++;
               wr_ready = 1'b0;
            end else if (wr_valid) begin
               wr_ready = 1'b1;
               q_idx.push_back(int'(lut_index));
               q_addr.push_back(wr_addr);
               q_data.push_back(wr_data);
               q_vcyc.push_back(cur_vcyc);
               phase = 1;
               dly = 2;
            end else begin
               wr_ready = 1'b0;
            end
         end else begin
            wr_ready = 1'b0;
            if (dly == 2) check_eq("valid_drop", 32'(wr_valid), 32'd0);
            dly--;
            if (dly == 0) begin
               wr_done = 1'b1;
               wr_nack = (q_idx[$] == nack_idx) && (nack_left > 0);
               if (wr_nack) nack_left--;
               q_dcyc.push_back(cyc);
               n_done++;
               phase = 0;
               seen = 0;
            end
         end
      end
   end

   int start_cyc = 0;

   task automatic start_run(input logic [8:0] sz);
      @(negedge clk);
      lut_size = sz;
      start = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int maxc);
      int n = 0;
      while (busy && n < maxc) begin
         @(negedge clk);
         n++;
      end
      check_eq("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic clear_logs();
      q_idx.delete(); q_addr.delete(); q_data.delete(); q_vcyc.delete(); q_dcyc.delete();
      n_done = 0;
   endtask

   task automatic check_seq(input string tag, input int exp_idx[$]);
      check_eq({tag, "_count"}, 32'(q_idx.size()), 32'(exp_idx.size()));
      for (int i = 0; i < exp_idx.size(); i++) begin
         if (i < q_idx.size()) begin
            check_eq({tag, "_idx"}, 32'(q_idx[i]), 32'(exp_idx[i]));
            check_eq({tag, "_addr"}, 32'(q_addr[i]), 32'(lut[exp_idx[i]][23:8]));
            check_eq({tag, "_data"}, 32'(q_data[i]), 32'(lut[exp_idx[i]][7:0]));
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int wn;
      lut[0] = 24'h3103_11;
      lut[1] = 24'h3008_82;
      lut[2] = 24'h3008_42;
      lut[3] = 24'h3103_03;
      rst = 1'b1;
      start = 1'b0;
      lut_size = 9'd0;
      repeat (3) @(negedge clk);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_valid", 32'(wr_valid), 32'd0);
      check_eq("rst_done", 32'(cfg_done), 32'd0);
      check_eq("rst_err", 32'(cfg_err), 32'd0);
      check_eq("rst_index", 32'(lut_index), 32'd0);
      check_eq("rst_addr", 32'(wr_addr), 32'd0);
      rst = 1'b0;

      // 1/2: plain run, all ACK
      clear_logs();
      start_run(9'd4);
      check_eq("t1_busy_rise", 32'(busy), 32'd1);
      wait_idle(2000);
      check_seq("t1", '{0, 1, 2, 3});
      check_eq("t1_first_gap", 32'((q_vcyc.size() > 0) && (q_vcyc[0] - start_cyc >= 11)), 32'd1);
      check_eq("t1_done", 32'(cfg_done), 32'd1);
      check_eq("t1_err", 32'(cfg_err), 32'd0);
      if (q_vcyc.size() == 4 && q_dcyc.size() == 4) begin
         check_eq("t2_settle_gap", 32'(q_vcyc[2] - q_dcyc[1] >= 20), 32'd1);
         check_eq("t2_gap01", 32'(q_vcyc[1] - q_dcyc[0] <= 3), 32'd1);
         check_eq("t2_gap23", 32'(q_vcyc[3] - q_dcyc[2] <= 3), 32'd1);
      end else begin
         check_eq("t2_log_len", 32'(q_dcyc.size()), 32'd4);
      end

      // 3: NACK idx2 twice then ACK
      clear_logs();
      nack_idx = 2; nack_left = 2;
      start_run(9'd4);
      check_eq("t3_done_clr", 32'(cfg_done), 32'd0);
      wait_idle(2000);
      check_seq("t3", '{0, 1, 2, 2, 2, 3});
      check_eq("t3_done", 32'(cfg_done), 32'd1);
      check_eq("t3_err", 32'(cfg_err), 32'd0);

      // 4: NACK idx2 always
      clear_logs();
      nack_idx = 2; nack_left = 100;
      start_run(9'd4);
      wait_idle(2000);
      check_seq("t4", '{0, 1, 2, 2, 2});
      check_eq("t4_err", 32'(cfg_err), 32'd1);
      check_eq("t4_err_index", 32'(err_index), 32'd2);
      check_eq("t4_done", 32'(cfg_done), 32'd0);

      // 5: ready stall on idx1, ignored mid-run start, restart after DONE
      clear_logs();
      nack_idx = -1; nack_left = 0;
      stall_armed = 1; stall_idx = 1; stall_n = 7; stall_cnt = 0;
      start_run(9'd4);
      check_eq("t5_err_clr", 32'(cfg_err), 32'd0);
      repeat (4) @(negedge clk);
      lut_size = 9'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0; lut_size = 9'd4;
      wait_idle(2000);
      check_seq("t5", '{0, 1, 2, 3});
      check_eq("t5_first_gap", 32'((q_vcyc.size() > 0) ? q_vcyc[0] - start_cyc : -1), 32'd12);
      check_eq("t5_stall_len", 32'(stall_cnt), 32'd7);
      check_eq("t5_done", 32'(cfg_done), 32'd1);
      start_run(9'd4);
      check_eq("t5_rerun_done_clr", 32'(cfg_done), 32'd0);
      check_eq("t5_rerun_busy", 32'(busy), 32'd1);
      wait_idle(2000);
      check_eq("t5_rerun_count", 32'(q_idx.size()), 32'd8);
      check_eq("t5_rerun_idx0", 32'((q_idx.size() > 4) ? q_idx[4] : -1), 32'd0);
      check_eq("t5_rerun_done", 32'(cfg_done), 32'd1);

      // 6: reset during SETTLE, then empty LUT
      clear_logs();
      start_run(9'd4);
      wn = 0;
      while (n_done < 2 && wn < 500) begin
         @(negedge clk);
         wn++;
      end
      check_eq("t6_wait_settle", 32'(n_done >= 2), 32'd1);
      repeat (5) @(negedge clk);
      check_eq("t6_in_settle", 32'(busy && !wr_valid && lut_index == 9'd1), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check_eq("t6_rst_busy", 32'(busy), 32'd0);
      check_eq("t6_rst_valid", 32'(wr_valid), 32'd0);
      check_eq("t6_rst_done", 32'(cfg_done), 32'd0);
      check_eq("t6_rst_err", 32'(cfg_err), 32'd0);
      check_eq("t6_rst_index", 32'(lut_index), 32'd0);
      check_eq("t6_rst_addr", 32'(wr_addr), 32'd0);
      check_eq("t6_rst_data", 32'(wr_data), 32'd0);
      check_eq("t6_rst_err_index", 32'(err_index), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      clear_logs();
      start_run(9'd0);
      check_eq("t6_empty_done", 32'(cfg_done), 32'd1);
      check_eq("t6_empty_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      check_eq("t6_empty_writes", 32'(q_idx.size()), 32'd0);
      check_eq("t6_empty_done_hold", 32'(cfg_done), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
